// File: rtl/axi_fifo_pkt.sv
// axi_fifo_pkt: single-clock AXI-Stream FIFO carrying tlast, with occupancy/space
// reporting, a programmable almost-full flag and an optional store-and-forward mode.
module axi_fifo_pkt #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 5,
  parameter bit PKT_MODE  = 1'b0,
  parameter int AF_THRESH = (1 << SIZE) - 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [SIZE:0]    occupied,
  output logic [SIZE:0]    space,
  output logic             almost_full,
  output logic [SIZE:0]    pkt_count
);
  localparam int              DEPTH    = 1 << SIZE;
  localparam logic [SIZE:0]   FULL_CNT = {1'b1, {SIZE{1'b0}}};
  localparam logic [SIZE:0]   CNT_ONE  = {{SIZE{1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] PTR_ONE  = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE:0]   AF_CNT   = AF_THRESH[SIZE:0];

  logic [WIDTH:0]  r_mem [DEPTH];
  logic [SIZE-1:0] r_wr_ptr;
  logic [SIZE-1:0] r_rd_ptr;
  logic [SIZE:0]   r_occupied;
  logic [SIZE:0]   r_pkt_count;
  logic            r_in_ready;
  logic            r_almost_full;
  logic            r_jumbo;

  logic [SIZE:0]   w_occ_next;
  logic [SIZE:0]   w_pkt_next;
  logic [WIDTH:0]  w_rd_word;
  logic            w_flush;
  logic            w_push;
  logic            w_pop;
  logic            w_push_last;
  logic            w_pop_last;
  logic            w_jumbo;

  assign w_flush     = ~reset_n | clear;
  assign w_rd_word   = r_mem[r_rd_ptr];
  assign w_push      = i_tvalid & r_in_ready;
  assign w_pop       = o_tvalid & o_tready;
  assign w_push_last = w_push & i_tlast;
  assign w_pop_last  = w_pop & w_rd_word[WIDTH];

  // A full FIFO holding no tlast can never complete a packet, so it must cut through.
  assign w_jumbo = r_jumbo | ((r_occupied == FULL_CNT) & (r_pkt_count == '0));

  generate
    if (PKT_MODE) begin : g_pkt
      assign o_tvalid = (r_occupied != '0) & ((r_pkt_count != '0) | w_jumbo);
    end else begin : g_stream
      assign o_tvalid = (r_occupied != '0);
    end
  endgenerate

  always_comb begin
    w_occ_next = r_occupied;
    w_pkt_next = r_pkt_count;
    if (w_push & ~w_pop) begin
      w_occ_next = r_occupied + CNT_ONE;
    end else if (~w_push & w_pop) begin
      w_occ_next = r_occupied - CNT_ONE;
    end
    if (w_push_last & ~w_pop_last) begin
      w_pkt_next = r_pkt_count + CNT_ONE;
    end else if (~w_push_last & w_pop_last) begin
      w_pkt_next = r_pkt_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_occupied    <= '0;
      r_pkt_count   <= '0;
      r_in_ready    <= 1'b0;
      r_almost_full <= 1'b0;
      r_jumbo       <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_occupied    <= w_occ_next;
      r_pkt_count   <= w_pkt_next;
      r_in_ready    <= (w_occ_next != FULL_CNT);
      r_almost_full <= (w_occ_next >= AF_CNT);
      if (w_pop_last) begin
        r_jumbo <= 1'b0;
      end else if (w_jumbo) begin
        r_jumbo <= 1'b1;
      end
    end
  end

  // Storage is not cleared on flush; stale words become unreachable.
  always_ff @(posedge clk) begin
    if (w_push & ~w_flush) begin
      r_mem[r_wr_ptr] <= {i_tlast, i_tdata};
    end
  end

  assign i_tready    = r_in_ready;
  assign o_tdata     = w_rd_word[WIDTH-1:0];
  assign o_tlast     = w_rd_word[WIDTH];
  assign occupied    = r_occupied;
  assign space       = FULL_CNT - r_occupied;
  assign almost_full = r_almost_full;
  assign pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_axi_fifo_pkt.sv
// Scoreboard bench for axi_fifo_pkt: a stream-mode (SIZE=4) and a packet-mode (SIZE=3)
// instance, each checked every cycle against a queue-based reference model.
module tb_axi_fifo_pkt;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data [2];
  logic        in_last [2];
  logic        in_valid [2];
  logic        out_ready [2];
  logic        clr [2];
  logic        in_ready [2];
  logic [31:0] out_data [2];
  logic        out_last [2];
  logic        out_valid [2];
  logic        af [2];
  logic [4:0]  occ0, space0, pkt0;
  logic [3:0]  occ1, space1, pkt1;
  logic [7:0]  occ_v [2];
  logic [7:0]  space_v [2];
  logic [7:0]  pkt_v [2];
  int          n_tests = 0;
  int          n_fail = 0;
  int          model_size [2];
  bit          rand_rdy [2];

  always #5 clk = ~clk;

  axi_fifo_pkt #(.WIDTH(32), .SIZE(4), .PKT_MODE(1'b0)) u_stream (
    .clk(clk), .reset_n(rst_n), .clear(clr[0]),
    .i_tdata(in_data[0]), .i_tlast(in_last[0]), .i_tvalid(in_valid[0]), .i_tready(in_ready[0]),
    .o_tdata(out_data[0]), .o_tlast(out_last[0]), .o_tvalid(out_valid[0]), .o_tready(out_ready[0]),
    .occupied(occ0), .space(space0), .almost_full(af[0]), .pkt_count(pkt0)
  );

  axi_fifo_pkt #(.WIDTH(32), .SIZE(3), .PKT_MODE(1'b1)) u_pkt (
    .clk(clk), .reset_n(rst_n), .clear(clr[1]),
    .i_tdata(in_data[1]), .i_tlast(in_last[1]), .i_tvalid(in_valid[1]), .i_tready(in_ready[1]),
    .o_tdata(out_data[1]), .o_tlast(out_last[1]), .o_tvalid(out_valid[1]), .o_tready(out_ready[1]),
    .occupied(occ1), .space(space1), .almost_full(af[1]), .pkt_count(pkt1)
  );

  assign occ_v[0]   = {3'b000, occ0};
  assign space_v[0] = {3'b000, space0};
  assign pkt_v[0]   = {3'b000, pkt0};
  assign occ_v[1]   = {4'b0000, occ1};
  assign space_v[1] = {4'b0000, space1};
  assign pkt_v[1]   = {4'b0000, pkt1};

  task automatic check(input int inst, input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got 0x%0h expected 0x%0h at %0t", inst, name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds one word on the input until accepted, then idles for gap cycles.
  task automatic send(input int inst, input logic [31:0] d, input logic l, input int gap);
    bit ok = 1'b0;
    in_data[inst]  = d;
    in_last[inst]  = l;
    in_valid[inst] = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready[inst];
      @(posedge clk);
      #1;
    end
    in_valid[inst] = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL inst%0d send_timeout: got no i_tready expected accept within 200 cycles", inst);
    end
    if (gap > 0) tick(gap);
  endtask

  task automatic drain(input int inst);
    bit done = 1'b0;
    out_ready[inst] = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      if (model_size[inst] == 0) done = 1'b1;
      else tick(1);
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL inst%0d drain_timeout: got %0d words left expected 0", inst, model_size[inst]);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    localparam int D  = (gi == 0) ? 16 : 8;
    localparam int AF = D - 2;
    localparam bit PK = (gi == 1);
    logic [32:0] q [$];

    initial begin
      forever begin
        @(posedge clk);
        #1;
        if (rand_rdy[gi]) out_ready[gi] = ($urandom_range(3) != 0);
      end
    end

    // Reference model: the queue is the FIFO content; flags follow from its size and tlasts.
    initial begin
      bit          m_ready;
      bit          m_jumbo;
      bit          m_valid;
      bit          full_nopkt;
      int          nlast;
      logic [32:0] w;
      m_ready = 1'b0;
      m_jumbo = 1'b0;
      model_size[gi] = 0;
      @(posedge clk);
      forever begin
        @(negedge clk);
        nlast = 0;
        foreach (q[k]) if (q[k][32]) nlast++;
        full_nopkt = (q.size() == D) && (nlast == 0);
        m_valid = (q.size() != 0) && (!PK || nlast != 0 || m_jumbo || full_nopkt);
        check(gi, "i_tready", longint'(in_ready[gi]), longint'(m_ready));
        check(gi, "o_tvalid", longint'(out_valid[gi]), longint'(m_valid));
        check(gi, "occupied", longint'(occ_v[gi]), longint'(q.size()));
        check(gi, "space", longint'(space_v[gi]), longint'(D - q.size()));
        check(gi, "almost_full", longint'(af[gi]), longint'(q.size() >= AF));
        check(gi, "pkt_count", longint'(pkt_v[gi]), longint'(nlast));
        if (!rst_n || clr[gi]) begin
          q.delete();
          m_ready = 1'b0;
          m_jumbo = 1'b0;
        end else begin
          if (full_nopkt) m_jumbo = 1'b1;
          if (m_valid && out_ready[gi]) begin
            w = q.pop_front();
            check(gi, "o_tdata", longint'(out_data[gi]), longint'(w[31:0]));
            check(gi, "o_tlast", longint'(out_last[gi]), longint'(w[32]));
            if (w[32]) m_jumbo = 1'b0;
          end
          if (in_valid[gi] && m_ready) q.push_back({in_last[gi], in_data[gi]});
          m_ready = (q.size() != D);
        end
        model_size[gi] = q.size();
      end
    end
  end

  initial begin
    int len;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data[i] = '0; in_last[i] = 1'b0; in_valid[i] = 1'b0;
      out_ready[i] = 1'b0; clr[i] = 1'b0; rand_rdy[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);

    // Fill to full, offer a refused word, then drain in order.
    for (int i = 0; i < 16; i++) send(0, i, 1'b0, 0);
    in_data[0] = 32'h10;
    in_valid[0] = 1'b1;
    tick(3);
    in_valid[0] = 1'b0;
    drain(0);

    // Hold occupancy at 5 with concurrent push/pop across pointer wraps.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) send(0, 32'hA0 + i, 1'b0, 0);
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data[0] = $urandom;
      in_last[0] = $urandom_range(1);
      tick(1);
    end
    in_valid[0] = 1'b0;
    drain(0);

    // Random stream traffic with random backpressure.
    rand_rdy[0] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid[0] = ($urandom_range(2) != 0);
      in_data[0]  = $urandom;
      in_last[0]  = $urandom_range(1);
      tick(1);
    end
    in_valid[0] = 1'b0;
    rand_rdy[0] = 1'b0;
    drain(0);

    // Clear while words are visible on the stream output.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) send(0, 32'hE0 + i, 1'b0, 0);
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    send(0, 32'hEF, 1'b1, 2);
    drain(0);

    // Packet mode: gapped 3-word packet.
    out_ready[1] = 1'b1;
    send(1, 32'h11, 1'b0, 1);
    send(1, 32'h22, 1'b0, 1);
    send(1, 32'h33, 1'b1, 1);
    drain(1);

    // Jumbo: 12-word packet through an 8-deep FIFO.
    for (int i = 0; i < 12; i++) send(1, 32'hB00 + i, (i == 11), 0);
    drain(1);

    // Clear mid-packet, then a lone 1-word packet.
    out_ready[1] = 1'b0;
    send(1, 32'hC0, 1'b0, 0);
    send(1, 32'hC1, 1'b0, 0);
    clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    send(1, 32'hD0, 1'b1, 2);
    drain(1);

    // Random packets of 1..12 words with random backpressure.
    rand_rdy[1] = 1'b1;
    for (int p = 0; p < 20; p++) begin
      len = 1 + $urandom_range(11);
      for (int w = 0; w < len; w++) send(1, $urandom, (w == len - 1), $urandom_range(1));
    end
    rand_rdy[1] = 1'b0;
    drain(1);

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
